// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings,
// error codes and the instruction-memory base address.
package im_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_HI = 3'd1;
  localparam logic [2:0] ST_HDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CKSUM  = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CKSUM = 2'd2;

  localparam logic [31:0] IM_BASE = 32'h0000_3000;

  // States in which a stream byte may be accepted.
  function automatic logic accepts_bytes(input logic [2:0] st);
    return (st == ST_HDR_HI) || (st == ST_HDR_LO) || (st == ST_DATA) || (st == ST_CKSUM);
  endfunction

  // States in which the CPU is held in reset.
  function automatic logic holds_cpu(input logic [2:0] st);
    return accepts_bytes(st) || (st == ST_ERR);
  endfunction

endpackage

// File: rtl/im_word_packer.sv
// Shifts stream bytes MSB-first into a 32-bit word and emits a registered
// one-cycle write strobe the clock after the fourth byte of each word.
module im_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        word_we,
  output logic [31:0] word
);

  logic [23:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      lane    <= '0;
      word_we <= 1'b0;
      word    <= '0;
    end else begin
      word_we <= 1'b0;
      if (clr) begin
        shift <= '0;
        lane  <= '0;
      end else if (byte_en) begin
        shift <= {shift[15:0], byte_in};
        lane  <= lane + 2'd1;
        if (lane == 2'd3) begin
          word    <= {shift, byte_in};
          word_we <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Loads a framed byte stream (count header, big-endian words, XOR checksum)
// into the instruction memory while holding the CPU in reset.
module im_loader #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  import im_loader_pkg::*;

  logic [2:0]      state, state_nxt;
  logic [7:0]      cnt_hi;
  logic [15:0]     n_words;
  logic [ADDR_W:0] ptr;
  logic [7:0]      acc;
  logic [1:0]      lane;
  logic [15:0]     hdr_n;
  logic            hdr_bad;
  logic            xfer;
  logic            last_byte;
  logic            pk_en;
  logic            pk_clr;

  assign xfer      = s_valid & s_ready;
  assign hdr_n     = {cnt_hi, s_data};
  assign hdr_bad   = (hdr_n == 16'd0) || (hdr_n > 16'(MEM_WORDS));
  assign last_byte = (lane == 2'd3) && (16'(ptr) == n_words - 16'd1);
  assign pk_en     = xfer && (state == ST_DATA) && !load_abort;
  assign pk_clr    = load_abort || (state != ST_DATA);

  im_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pk_clr),
    .byte_en (pk_en),
    .byte_in (s_data),
    .lane    (lane),
    .word_we (im_we),
    .word    (im_wdata)
  );

  always_comb begin
    state_nxt = state;
    if (load_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (load_start) state_nxt = ST_HDR_HI;
        ST_HDR_HI: if (xfer) state_nxt = ST_HDR_LO;
        ST_HDR_LO: if (xfer) state_nxt = hdr_bad ? ST_ERR : ST_DATA;
        ST_DATA:   if (xfer && last_byte) state_nxt = ST_CKSUM;
        ST_CKSUM:  if (xfer) state_nxt = (s_data == acc) ? ST_IDLE : ST_ERR;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // s_ready/cpu_hold are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_ready   <= 1'b0;
      cpu_hold  <= 1'b0;
      cnt_hi    <= '0;
      n_words   <= '0;
      ptr       <= '0;
      acc       <= '0;
      im_waddr  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      s_ready   <= accepts_bytes(state_nxt);
      cpu_hold  <= holds_cpu(state_nxt);
      load_done <= 1'b0;
      if (!load_abort) begin
        case (state)
          ST_IDLE: begin
            if (load_start) begin
              load_err <= 1'b0;
              err_code <= ERR_NONE;
            end
          end
          ST_HDR_HI: begin
            if (xfer) cnt_hi <= s_data;
          end
          ST_HDR_LO: begin
            if (xfer) begin
              n_words <= hdr_n;
              ptr     <= '0;
              acc     <= '0;
              if (hdr_bad) begin
                load_err <= 1'b1;
                err_code <= ERR_COUNT;
              end
            end
          end
          ST_DATA: begin
            if (xfer) begin
              acc <= acc ^ s_data;
              if (lane == 2'd3) begin
                im_waddr <= ptr[ADDR_W-1:0];
                ptr      <= ptr + 1'b1;
              end
            end
          end
          ST_CKSUM: begin
            if (xfer) begin
              if (s_data == acc) begin
                load_done <= 1'b1;
              end else begin
                load_err <= 1'b1;
                err_code <= ERR_CKSUM;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected IM writes are queued as frames are
// driven; a negedge monitor pops and compares on every im_we.
module tb_im_loader;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  wr_t exp_q[$];
  logic [7:0] frame[$];

  im_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_abort (load_abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (im_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", im_waddr, im_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(im_waddr), 32'(e.addr));
          chk("wr_data", im_wdata, e.data);
        end
      end
      if (load_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 20) begin
      tick();
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got s_ready 0 expected 1 within 20 cycles");
      s_valid = 1'b0;
      return;
    end
    tick();
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      chk("gap_ready", 32'(s_ready), 32'd1);
      chk("gap_hold", 32'(cpu_hold), 32'd1);
      tick();
    end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], (i == frame.size() - 1) ? 0 : gap);
  endtask

  task automatic load_frame1();
    // Checksum is the XOR of the eight data bytes: 0x1D.
    frame = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h34, 8'h09, 8'h00, 8'h04, 8'h1D};
  endtask

  task automatic push_frame1();
    exp_q.push_back('{addr: 8'd0, data: 32'h3C08_0010});
    exp_q.push_back('{addr: 8'd1, data: 32'h3409_0004});
  endtask

  initial begin : stim
    int d0;
    #12;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1) two-word frame, back-to-back bytes
    d0 = done_cnt;
    load_frame1();
    push_frame1();
    start();
    chk("t1_hold_start", 32'(cpu_hold), 32'd1);
    chk("t1_ready_start", 32'(s_ready), 32'd1);
    send_frame(0);
    tick();
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_code", 32'(err_code), 32'(2'd0));
    chk("t1_hold_after", 32'(cpu_hold), 32'd0);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // 2) same frame, one idle cycle between bytes
    d0 = done_cnt;
    push_frame1();
    start();
    send_frame(1);
    tick();
    chk("t2_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_err", 32'(load_err), 32'd0);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // 3) word count 257 is rejected
    d0 = done_cnt;
    start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_hold_err", 32'(cpu_hold), 32'd1);
    chk("t3_ready_err", 32'(s_ready), 32'd0);
    tick();
    chk("t3_hold_idle", 32'(cpu_hold), 32'd0);
    chk("t3_err_sticky", 32'(load_err), 32'd1);
    chk("t3_done", 32'(done_cnt - d0), 32'd0);

    // 4) bad checksum: words still written, then error 2
    d0 = done_cnt;
    load_frame1();
    frame[10] = 8'hFF;
    push_frame1();
    start();
    chk("t4_err_cleared", 32'(load_err), 32'd0);
    chk("t4_code_cleared", 32'(err_code), 32'd0);
    send_frame(0);
    chk("t4_code", 32'(err_code), 32'd2);
    chk("t4_err", 32'(load_err), 32'd1);
    tick();
    chk("t4_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // 5) asynchronous reset after two data bytes
    start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h08, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", 32'(s_ready), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd0);
    chk("t5_we", 32'(im_we), 32'd0);
    chk("t5_waddr", 32'(im_waddr), 32'd0);
    chk("t5_wdata", im_wdata, 32'd0);
    chk("t5_done", 32'(load_done), 32'd0);
    chk("t5_err", 32'(load_err), 32'd0);
    chk("t5_code", 32'(err_code), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    load_frame1();
    push_frame1();
    start();
    send_frame(0);
    tick();
    chk("t5_reload_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);

    // 6) abort mid-word, then a one-word frame
    start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    chk("t6_hold_abort", 32'(cpu_hold), 32'd0);
    chk("t6_ready_abort", 32'(s_ready), 32'd0);
    tick();
    d0 = done_cnt;
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    exp_q.push_back('{addr: 8'd0, data: 32'h1122_3344});
    start();
    send_frame(0);
    tick();
    chk("t6_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_code", 32'(err_code), 32'd0);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
